// File: rtl/bmult_arbiter.sv
// Round-robin arbiter sharing one pipelined 32x32 multiplier between NREQ requesters.
// Optional perf counters (perf_issue/perf_stall) are enabled with `define BMULT_ARB_PERF_EN.
module bmult_arbiter #(
    parameter int NREQ       = 4,
    parameter int MULT_LAT   = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int IDW        = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic [31:0]        mult_a,
    output logic [31:0]        mult_b,
    input  logic [63:0]        mult_p,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDW-1:0]     res_id,
    output logic [63:0]        res_p
`ifdef BMULT_ARB_PERF_EN
    ,
    output logic [31:0]        perf_issue,
    output logic [31:0]        perf_stall
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [IDW-1:0] ptr;
    logic [CW-1:0]  inflight;
    logic [CW-1:0]  fifo_count;
    logic           credit_ok;
    logic           accept;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] idx;

    logic [MULT_LAT-1:0] pipe_vld;
    logic [IDW-1:0]      pipe_id [MULT_LAT];
    logic                push;
    logic                pop;

    logic [IDW-1:0] mem_id [FIFO_DEPTH];
    logic [63:0]    mem_p  [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Credit covers every operation that will eventually need a FIFO slot.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_W;

    always_comb begin
        accept    = 1'b0;
        grant_id  = '0;
        idx       = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!accept && req_valid[idx]) begin
                accept   = 1'b1;
                grant_id = idx;
            end
        end
        if (!credit_ok || !rst_n) begin
            accept = 1'b0;
        end
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            mult_a <= '0;
            mult_b <= '0;
        end else if (accept) begin
            ptr    <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            mult_a <= req_a[32*grant_id +: 32];
            mult_b <= req_b[32*grant_id +: 32];
        end
    end

    // ID pipeline runs in lockstep with the multiplier latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int s = 0; s < MULT_LAT; s++) begin
                pipe_id[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept;
            pipe_id[0]  <= grant_id;
            for (int s = 1; s < MULT_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_id[s]  <= pipe_id[s-1];
            end
        end
    end

    assign push = pipe_vld[MULT_LAT-1];
    assign pop  = res_valid & res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({accept, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr] <= pipe_id[MULT_LAT-1];
            mem_p[wr_ptr]  <= mult_p;
        end
    end

    // Head is gated so the result port reads zero while the FIFO is empty.
    assign res_valid = (fifo_count != '0);
    assign res_id    = res_valid ? mem_id[rd_ptr] : '0;
    assign res_p     = res_valid ? mem_p[rd_ptr]  : '0;

`ifdef BMULT_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue <= '0;
            perf_stall <= '0;
        end else begin
            if (accept) begin
                perf_issue <= perf_issue + 32'd1;
            end
            if (|req_valid && !accept) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
